// File: rtl/as_src_mac_checker_pkg.sv
// Shared encodings for the source-MAC anti-spoof checker.
// Table entries are laid out as {valid, port[NUM_IQ_BITS], mac[48]}.
package as_src_mac_checker_pkg;
  localparam int MAC_W         = 48;
  localparam int MAC_MCAST_BIT = 40;
  localparam int ENT_MAC_LSB   = 0;
  localparam int ENT_PORT_LSB  = MAC_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_SEARCH = 3'b010,
    ST_RESULT = 3'b100
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/as_src_mac_checker_if.sv
// Parser-side / verdict-side signal bundle of the MAC checker.
interface as_src_mac_checker_if #(parameter int NUM_IQ_BITS = 3);
  logic [47:0]            src_mac;
  logic [NUM_IQ_BITS-1:0] src_port;
  logic                   eth_done;
  logic                   table_flush;
  logic                   check_done;
  logic                   is_spoof;
  logic                   is_new;
  logic                   check_rd;
  logic [15:0]            spoof_cnt;
  logic [15:0]            busy_drop_cnt;

  modport master (
    output src_mac, src_port, eth_done, table_flush, check_rd,
    input  check_done, is_spoof, is_new, spoof_cnt, busy_drop_cnt
  );
  modport slave (
    input  src_mac, src_port, eth_done, table_flush, check_rd,
    output check_done, is_spoof, is_new, spoof_cnt, busy_drop_cnt
  );
endinterface

// File: rtl/as_src_mac_checker_table.sv
// MAC->port binding store: combinational read, one write port, one-cycle flush.
module as_mac_table
  import as_src_mac_checker_pkg::*;
#(
  parameter int NUM_IQ_BITS     = 3,
  parameter int TABLE_DEPTH     = 16,
  parameter int TABLE_ADDR_BITS = 4,
  localparam int ENTRY_W        = 1 + NUM_IQ_BITS + MAC_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [TABLE_ADDR_BITS-1:0] rd_idx,
  output logic [ENTRY_W-1:0]         rd_entry,
  input  logic                       wr_en,
  input  logic [TABLE_ADDR_BITS-1:0] wr_idx,
  input  logic [ENTRY_W-1:0]         wr_entry,
  input  logic                       flush
);
  logic [TABLE_DEPTH-1:0][ENTRY_W-1:0] ent_q, ent_d;

  always_comb begin
    ent_d = ent_q;
    if (flush) begin
      for (int i = 0; i < TABLE_DEPTH; i++) ent_d[i][ENTRY_W-1] = 1'b0;
    end else if (wr_en) begin
      ent_d[wr_idx] = wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ent_q <= '0;
    else       ent_q <= ent_d;
  end

  assign rd_entry = ent_q[rd_idx];
endmodule

// File: rtl/as_src_mac_checker.sv
// Anti-spoof check: linear search of the binding table on each header,
// learning unseen unicast MACs round-robin and holding the verdict until read.
module as_src_mac_checker
  import as_src_mac_checker_pkg::*;
#(
  parameter int NUM_IQ_BITS     = 3,
  parameter int TABLE_DEPTH     = 16,
  parameter int TABLE_ADDR_BITS = 4,
  parameter bit LEARN_EN        = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  as_src_mac_checker_if.slave     bus
);
  localparam int ENTRY_W = 1 + NUM_IQ_BITS + MAC_W;
  localparam logic [TABLE_ADDR_BITS-1:0] LAST_IDX = TABLE_ADDR_BITS'(TABLE_DEPTH - 1);

  state_t                     state_q, state_d;
  logic [TABLE_ADDR_BITS-1:0] idx_q, idx_d, wr_ptr_q, wr_ptr_d;
  logic [MAC_W-1:0]           mac_q, mac_d;
  logic [NUM_IQ_BITS-1:0]     port_q, port_d;
  logic                       spoof_q, spoof_d, new_q, new_d;
  logic                       flush_pend_q, flush_pend_d;
  logic                       eth_dly_q, eth_dly_d;
  logic [15:0]                spoof_cnt_q, spoof_cnt_d, drop_cnt_q, drop_cnt_d;

  logic                       rise, start, do_flush, wr_en, hit;
  logic [ENTRY_W-1:0]         rd_entry;

  as_mac_table #(
    .NUM_IQ_BITS(NUM_IQ_BITS), .TABLE_DEPTH(TABLE_DEPTH), .TABLE_ADDR_BITS(TABLE_ADDR_BITS)
  ) u_table (
    .clk(clk), .reset(reset),
    .rd_idx(idx_q), .rd_entry(rd_entry),
    .wr_en(wr_en), .wr_idx(wr_ptr_q), .wr_entry({1'b1, port_q, mac_q}),
    .flush(do_flush)
  );

  assign rise  = bus.eth_done & ~eth_dly_q;
  assign start = rise & (state_q == ST_IDLE);
  assign hit   = rd_entry[ENTRY_W-1] & (rd_entry[ENT_MAC_LSB +: MAC_W] == mac_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      wr_ptr_q     <= '0;
      mac_q        <= '0;
      port_q       <= '0;
      spoof_q      <= 1'b0;
      new_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      eth_dly_q    <= 1'b0;
      spoof_cnt_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wr_ptr_q     <= wr_ptr_d;
      mac_q        <= mac_d;
      port_q       <= port_d;
      spoof_q      <= spoof_d;
      new_q        <= new_d;
      flush_pend_q <= flush_pend_d;
      eth_dly_q    <= eth_dly_d;
      spoof_cnt_q  <= spoof_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_ptr_d  = wr_ptr_q;
    mac_d     = mac_q;
    port_d    = port_q;
    spoof_d   = spoof_q;
    new_d     = new_q;
    eth_dly_d = bus.eth_done;
    wr_en     = 1'b0;
    // A flush waits for a quiet IDLE cycle so an in-flight search sees the old table.
    do_flush     = (state_q == ST_IDLE) & ~start & (bus.table_flush | flush_pend_q);
    flush_pend_d = (bus.table_flush | flush_pend_q) & ~do_flush;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mac_d  = bus.src_mac;
          port_d = bus.src_port;
          idx_d  = '0;
          if (bus.src_mac[MAC_MCAST_BIT]) begin
            state_d = ST_RESULT;
            spoof_d = 1'b1;
            new_d   = 1'b0;
          end else begin
            state_d = ST_SEARCH;
          end
        end
      end
      ST_SEARCH: begin
        if (hit) begin
          state_d = ST_RESULT;
          spoof_d = (rd_entry[ENT_PORT_LSB +: NUM_IQ_BITS] != port_q);
          new_d   = 1'b0;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_RESULT;
          spoof_d = ~LEARN_EN;
          new_d   = LEARN_EN;
          if (LEARN_EN) begin
            wr_en    = 1'b1;
            wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + TABLE_ADDR_BITS'(1);
          end
        end else begin
          idx_d = idx_q + TABLE_ADDR_BITS'(1);
        end
      end
      ST_RESULT: if (bus.check_rd) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (do_flush) wr_ptr_d = '0;

    spoof_cnt_d = spoof_cnt_q;
    if ((state_q != ST_RESULT) && (state_d == ST_RESULT) && spoof_d)
      spoof_cnt_d = sat_inc16(spoof_cnt_q);
    drop_cnt_d = (rise && state_q != ST_IDLE) ? sat_inc16(drop_cnt_q) : drop_cnt_q;
  end

  always_comb begin
    bus.check_done    = (state_q == ST_RESULT);
    bus.is_spoof      = spoof_q;
    bus.is_new        = new_q;
    bus.spoof_cnt     = spoof_cnt_q;
    bus.busy_drop_cnt = drop_cnt_q;
  end
endmodule

// File: tb/tb_as_src_mac_checker.sv
// Directed-vector bench for as_src_mac_checker; latencies counted in clocks from the eth_done rise.
module tb_as_src_mac_checker;
  logic clk = 1'b0;
  logic reset;
  int   vec = 0;
  int   err = 0;

  localparam logic [47:0] MAC_A  = 48'h0011_2233_4455;
  localparam logic [47:0] MAC_MC = 48'h0100_5E00_0001;

  as_src_mac_checker_if #(.NUM_IQ_BITS(3)) bus ();
  as_src_mac_checker #(.NUM_IQ_BITS(3), .TABLE_DEPTH(16), .TABLE_ADDR_BITS(4), .LEARN_EN(1'b1))
    dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  function automatic logic [47:0] mk_mac(input int i);
    return {24'h02AA00, 24'(i)};
  endfunction

  // Raise eth_done with a new header; lat = clocks until check_done (40 = timeout).
  task automatic send(input logic [47:0] mac, input logic [2:0] port, output int lat);
    bus.src_mac  = mac;
    bus.src_port = port;
    bus.eth_done = 1'b1;
    lat = 0;
    while (bus.check_done !== 1'b1 && lat < 40) begin cyc(); lat++; end
  endtask

  task automatic release_pkt();
    bus.check_rd = 1'b1;
    bus.eth_done = 1'b0;
    cyc();
    bus.check_rd = 1'b0;
    cyc();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.src_mac = '0; bus.src_port = '0; bus.eth_done = 1'b0;
    bus.table_flush = 1'b0; bus.check_rd = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    vec++; if (bus.check_done !== 1'b0) begin err++; $display("FAIL rst_check_done got %b exp 0", bus.check_done); end
    vec++; if (bus.is_spoof !== 1'b0) begin err++; $display("FAIL rst_is_spoof got %b exp 0", bus.is_spoof); end
    vec++; if (bus.is_new !== 1'b0) begin err++; $display("FAIL rst_is_new got %b exp 0", bus.is_new); end
    vec++; if (bus.spoof_cnt !== 16'd0) begin err++; $display("FAIL rst_spoof_cnt got %0d exp 0", bus.spoof_cnt); end
    vec++; if (bus.busy_drop_cnt !== 16'd0) begin err++; $display("FAIL rst_drop_cnt got %0d exp 0", bus.busy_drop_cnt); end
  endtask

  task automatic test_learn();
    int lat;
    send(MAC_A, 3'd2, lat);
    vec++; if (lat !== 17) begin err++; $display("FAIL learn_lat got %0d exp 17", lat); end
    vec++; if (bus.is_new !== 1'b1) begin err++; $display("FAIL learn_is_new got %b exp 1", bus.is_new); end
    vec++; if (bus.is_spoof !== 1'b0) begin err++; $display("FAIL learn_is_spoof got %b exp 0", bus.is_spoof); end
    release_pkt();
  endtask

  task automatic test_hit();
    int lat;
    send(MAC_A, 3'd2, lat);
    vec++; if (lat !== 2) begin err++; $display("FAIL hit_lat got %0d exp 2", lat); end
    vec++; if (bus.is_new !== 1'b0) begin err++; $display("FAIL hit_is_new got %b exp 0", bus.is_new); end
    vec++; if (bus.is_spoof !== 1'b0) begin err++; $display("FAIL hit_is_spoof got %b exp 0", bus.is_spoof); end
    release_pkt();
  endtask

  task automatic test_port_mismatch();
    int lat;
    send(MAC_A, 3'd5, lat);
    vec++; if (lat !== 2) begin err++; $display("FAIL mm_lat got %0d exp 2", lat); end
    vec++; if (bus.is_spoof !== 1'b1) begin err++; $display("FAIL mm_is_spoof got %b exp 1", bus.is_spoof); end
    vec++; if (bus.is_new !== 1'b0) begin err++; $display("FAIL mm_is_new got %b exp 0", bus.is_new); end
    vec++; if (bus.spoof_cnt !== 16'd1) begin err++; $display("FAIL mm_spoof_cnt got %0d exp 1", bus.spoof_cnt); end
    release_pkt();
    send(MAC_A, 3'd2, lat);
    vec++; if (lat !== 2 || bus.is_spoof !== 1'b0) begin err++; $display("FAIL mm_still_bound lat %0d spoof %b exp 2/0", lat, bus.is_spoof); end
    release_pkt();
  endtask

  task automatic test_mcast();
    int lat;
    send(MAC_MC, 3'd1, lat);
    vec++; if (lat !== 1) begin err++; $display("FAIL mc_lat got %0d exp 1", lat); end
    vec++; if (bus.is_spoof !== 1'b1) begin err++; $display("FAIL mc_is_spoof got %b exp 1", bus.is_spoof); end
    vec++; if (bus.is_new !== 1'b0) begin err++; $display("FAIL mc_is_new got %b exp 0", bus.is_new); end
    vec++; if (bus.spoof_cnt !== 16'd2) begin err++; $display("FAIL mc_spoof_cnt got %0d exp 2", bus.spoof_cnt); end
    release_pkt();
    send(MAC_A, 3'd2, lat);
    vec++; if (lat !== 2 || bus.is_new !== 1'b0) begin err++; $display("FAIL mc_table_kept lat %0d new %b exp 2/0", lat, bus.is_new); end
    release_pkt();
  endtask

  // Flush in IDLE, then 17 learns: the 17th lands on entry 0 and evicts the first.
  task automatic test_wrap();
    int lat;
    bus.table_flush = 1'b1; cyc(); bus.table_flush = 1'b0; cyc();
    send(MAC_A, 3'd2, lat);
    vec++; if (lat !== 17 || bus.is_new !== 1'b1) begin err++; $display("FAIL flush_idle lat %0d new %b exp 17/1", lat, bus.is_new); end
    release_pkt();
    bus.table_flush = 1'b1; cyc(); bus.table_flush = 1'b0; cyc();
    for (int i = 0; i < 17; i++) begin
      send(mk_mac(i), 3'(i), lat);
      vec++; if (lat !== 17 || bus.is_new !== 1'b1) begin err++; $display("FAIL wrap_learn%0d lat %0d new %b exp 17/1", i, lat, bus.is_new); end
      release_pkt();
    end
    send(mk_mac(0), 3'd0, lat);
    vec++; if (lat !== 17 || bus.is_new !== 1'b1) begin err++; $display("FAIL wrap_relearn lat %0d new %b exp 17/1", lat, bus.is_new); end
    release_pkt();
    send(mk_mac(16), 3'd0, lat);
    vec++; if (lat !== 2 || bus.is_new !== 1'b0) begin err++; $display("FAIL wrap_slot0 lat %0d new %b exp 2/0", lat, bus.is_new); end
    release_pkt();
    send(mk_mac(2), 3'd2, lat);
    vec++; if (lat !== 4 || bus.is_spoof !== 1'b0) begin err++; $display("FAIL wrap_slot2 lat %0d spoof %b exp 4/0", lat, bus.is_spoof); end
    release_pkt();
  endtask

  task automatic test_flush_mid_search();
    int lat;
    bus.src_mac = mk_mac(5); bus.src_port = 3'd5; bus.eth_done = 1'b1;
    cyc(); cyc();
    bus.table_flush = 1'b1; cyc(); bus.table_flush = 1'b0;
    lat = 3;
    while (bus.check_done !== 1'b1 && lat < 40) begin cyc(); lat++; end
    vec++; if (lat !== 7 || bus.is_new !== 1'b0) begin err++; $display("FAIL flush_old_table lat %0d new %b exp 7/0", lat, bus.is_new); end
    release_pkt();
    send(mk_mac(5), 3'd5, lat);
    vec++; if (lat !== 17 || bus.is_new !== 1'b1) begin err++; $display("FAIL flush_applied lat %0d new %b exp 17/1", lat, bus.is_new); end
    release_pkt();
  endtask

  task automatic test_back_to_back();
    int lat;
    bit stable;
    send(mk_mac(5), 3'd5, lat);
    vec++; if (lat !== 2) begin err++; $display("FAIL b2b_lat got %0d exp 2", lat); end
    bus.eth_done = 1'b0; cyc();
    bus.eth_done = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.check_done !== 1'b1 || bus.is_spoof !== 1'b0 || bus.is_new !== 1'b0) stable = 1'b0;
    end
    vec++; if (stable !== 1'b1) begin err++; $display("FAIL b2b_hold_stable got %b exp 1", stable); end
    vec++; if (bus.busy_drop_cnt !== 16'd1) begin err++; $display("FAIL b2b_drop_cnt got %0d exp 1", bus.busy_drop_cnt); end
    bus.eth_done = 1'b0; cyc();
    bus.eth_done = 1'b1; bus.check_rd = 1'b1; cyc();
    bus.check_rd = 1'b0;
    repeat (3) cyc();
    vec++; if (bus.busy_drop_cnt !== 16'd2) begin err++; $display("FAIL b2b_rd_start_drop got %0d exp 2", bus.busy_drop_cnt); end
    vec++; if (bus.check_done !== 1'b0) begin err++; $display("FAIL b2b_no_restart got %b exp 0", bus.check_done); end
    bus.eth_done = 1'b0; cyc();
    bus.check_rd = 1'b1; cyc(); bus.check_rd = 1'b0; cyc();
    vec++; if (bus.check_done !== 1'b0) begin err++; $display("FAIL rd_without_done got %b exp 0", bus.check_done); end
    vec++; if (bus.spoof_cnt !== 16'd2) begin err++; $display("FAIL final_spoof_cnt got %0d exp 2", bus.spoof_cnt); end
  endtask

  task automatic test_reset_mid_search();
    bit seen;
    bus.src_mac = mk_mac(99); bus.src_port = 3'd1; bus.eth_done = 1'b1;
    repeat (3) cyc();
    reset = 1'b1; cyc(); reset = 1'b0; bus.eth_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin cyc(); if (bus.check_done !== 1'b0) seen = 1'b1; end
    vec++; if (seen !== 1'b0) begin err++; $display("FAIL rst_mid_no_verdict got %b exp 0", seen); end
    vec++; if (bus.spoof_cnt !== 16'd0) begin err++; $display("FAIL rst_mid_spoof_cnt got %0d exp 0", bus.spoof_cnt); end
  endtask

  initial begin
    test_reset();
    test_learn();
    test_hit();
    test_port_mismatch();
    test_mcast();
    test_wrap();
    test_flush_mid_search();
    test_back_to_back();
    test_reset_mid_search();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
